// File: rtl/alu_driver.sv
// Command front-end for the combinational alu: registers X/Y/m/s, waits a settle
// window, captures Z and returns it over a valid/ready result handshake.
module alu_driver #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_s,
    input  logic [1:0]  cmd_m,
    input  logic [7:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic        cmd_chain,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [1:0]  alu_m,
    output logic [1:0]  alu_s,
    input  logic [15:0] alu_z,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [7:0]  last_lo;
    logic        accept;
    logic        capture;
    logic        handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Only the low byte of the last captured Z is ever fed back as a chained X.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_x    <= '0;
            alu_y    <= '0;
            alu_m    <= '0;
            alu_s    <= '0;
            cnt      <= '0;
            res_data <= '0;
            last_lo  <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                alu_x <= cmd_chain ? last_lo : cmd_x;
                alu_y <= cmd_y;
                alu_m <= cmd_m;
                alu_s <= cmd_s;
                cnt   <= CNT_LOAD;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                res_data <= alu_z;
                last_lo  <= alu_z[7:0];
            end
            if (handshake) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: two instances (settle 1 and 4) with a stub alu Z={X,Y},
// checked against a transaction-level model of results, latency and counts.
module tb_alu_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2];
    logic        cmd_valid[2];
    logic        cmd_ready[2];
    logic [1:0]  cmd_s[2];
    logic [1:0]  cmd_m[2];
    logic [7:0]  cmd_x[2];
    logic [7:0]  cmd_y[2];
    logic        cmd_chain[2];
    logic [7:0]  alu_x[2];
    logic [7:0]  alu_y[2];
    logic [1:0]  alu_m[2];
    logic [1:0]  alu_s[2];
    logic [15:0] alu_z[2];
    logic        res_valid[2];
    logic        res_ready[2];
    logic [15:0] res_data[2];
    logic [15:0] op_count[2];

    assign alu_z[0] = {alu_x[0], alu_y[0]};
    assign alu_z[1] = {alu_x[1], alu_y[1]};

    alu_driver #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_s(cmd_s[0]), .cmd_m(cmd_m[0]), .cmd_x(cmd_x[0]), .cmd_y(cmd_y[0]),
        .cmd_chain(cmd_chain[0]), .alu_x(alu_x[0]), .alu_y(alu_y[0]), .alu_m(alu_m[0]),
        .alu_s(alu_s[0]), .alu_z(alu_z[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_data(res_data[0]), .op_count(op_count[0])
    );

    alu_driver #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_s(cmd_s[1]), .cmd_m(cmd_m[1]), .cmd_x(cmd_x[1]), .cmd_y(cmd_y[1]),
        .cmd_chain(cmd_chain[1]), .alu_x(alu_x[1]), .alu_y(alu_y[1]), .alu_m(alu_m[1]),
        .alu_s(alu_s[1]), .alu_z(alu_z[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_data(res_data[1]), .op_count(op_count[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what each instance should hold at transaction level.
    int          settle[2] = '{1, 4};
    logic [15:0] m_last[2];
    logic [15:0] m_count[2];
    logic [7:0]  m_x[2];
    logic [7:0]  m_y[2];
    logic [1:0]  m_s[2];
    logic [1:0]  m_m[2];
    longint      t_acc[2];
    longint      t_hs[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int u);
        chk($sformatf("rst_res_valid%0d", u), 32'(res_valid[u]), 0);
        chk($sformatf("rst_res_data%0d", u), 32'(res_data[u]), 0);
        chk($sformatf("rst_op_count%0d", u), 32'(op_count[u]), 0);
        chk($sformatf("rst_cmd_ready%0d", u), 32'(cmd_ready[u]), 1);
        chk($sformatf("rst_alu%0d", u), 32'({alu_x[u], alu_y[u], alu_s[u], alu_m[u]}), 0);
        m_last[u]  = '0;
        m_count[u] = '0;
        m_x[u] = '0; m_y[u] = '0; m_s[u] = '0; m_m[u] = '0;
    endtask

    // Called at a negedge with the instance idle; returns at the negedge after accept.
    task automatic start_op(input int u, input logic [7:0] x, input logic [7:0] y,
                            input logic [1:0] s, input logic [1:0] m, input logic ch);
        chk($sformatf("idle_cmd_ready%0d", u), 32'(cmd_ready[u]), 1);
        chk($sformatf("idle_res_valid%0d", u), 32'(res_valid[u]), 0);
        cmd_x[u] = x; cmd_y[u] = y; cmd_s[u] = s; cmd_m[u] = m; cmd_chain[u] = ch;
        cmd_valid[u] = 1'b1;
        res_ready[u] = 1'b0;
        @(posedge clk);
        t_acc[u] = longint'($time);
        @(negedge clk);
        cmd_valid[u] = 1'b0;
        m_x[u] = ch ? m_last[u][7:0] : x;
        m_y[u] = y; m_s[u] = s; m_m[u] = m;
    endtask

    function automatic logic [31:0] ops_now(input int u);
        return 32'({alu_x[u], alu_y[u], alu_s[u], alu_m[u]});
    endfunction

    function automatic logic [31:0] ops_exp(input int u);
        return 32'({m_x[u], m_y[u], m_s[u], m_m[u]});
    endfunction

    task automatic finish_op(input int u, input int hold);
        logic [15:0] z;
        z = {m_x[u], m_y[u]};
        for (int i = 0; i < settle[u]; i++) begin
            chk($sformatf("settle_res_valid%0d", u), 32'(res_valid[u]), 0);
            chk($sformatf("settle_cmd_ready%0d", u), 32'(cmd_ready[u]), 0);
            chk($sformatf("settle_alu%0d", u), ops_now(u), ops_exp(u));
            @(posedge clk);
            @(negedge clk);
        end
        chk($sformatf("resp_res_valid%0d", u), 32'(res_valid[u]), 1);
        chk($sformatf("resp_res_data%0d", u), 32'(res_data[u]), 32'(z));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_res_valid%0d", u), 32'(res_valid[u]), 1);
            chk($sformatf("bp_res_data%0d", u), 32'(res_data[u]), 32'(z));
            chk($sformatf("bp_cmd_ready%0d", u), 32'(cmd_ready[u]), 0);
            chk($sformatf("bp_alu%0d", u), ops_now(u), ops_exp(u));
            chk($sformatf("bp_op_count%0d", u), 32'(op_count[u]), 32'(m_count[u]));
        end
        res_ready[u] = 1'b1;
        @(posedge clk);
        t_hs[u] = longint'($time);
        @(negedge clk);
        res_ready[u] = 1'b0;
        m_count[u] = m_count[u] + 16'd1;
        m_last[u]  = z;
        chk($sformatf("hs_res_valid%0d", u), 32'(res_valid[u]), 0);
        chk($sformatf("hs_op_count%0d", u), 32'(op_count[u]), 32'(m_count[u]));
        chk($sformatf("hs_alu_kept%0d", u), ops_now(u), ops_exp(u));
    endtask

    task automatic pulse_reset(input int u, input logic rdy);
        rst[u] = 1'b1;
        res_ready[u] = rdy;
        @(posedge clk);
        @(negedge clk);
        rst[u] = 1'b0;
        res_ready[u] = 1'b0;
        check_reset(u);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; cmd_valid[u] = 1'b0; cmd_chain[u] = 1'b0; res_ready[u] = 1'b0;
            cmd_x[u] = '0; cmd_y[u] = '0; cmd_s[u] = '0; cmd_m[u] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check_reset(0);
        check_reset(1);

        // Chain straight after reset feeds X=0x00.
        start_op(0, 8'h99, 8'h55, 2'b00, 2'b00, 1'b1);
        finish_op(0, 0);
        chk("chain_after_reset", 32'(res_data[0]), 32'h0055);

        start_op(0, 8'h12, 8'h34, 2'b01, 2'b10, 1'b0);
        chk("basic_s", 32'(alu_s[0]), 32'h1);
        chk("basic_m", 32'(alu_m[0]), 32'h2);
        finish_op(0, 0);
        chk("basic_data", 32'(res_data[0]), 32'h1234);

        start_op(0, 8'hAB, 8'h01, 2'b11, 2'b01, 1'b0);
        finish_op(0, 0);
        chk("chain_op1", 32'(res_data[0]), 32'hAB01);
        start_op(0, 8'hFF, 8'h02, 2'b10, 2'b11, 1'b1);
        finish_op(0, 0);
        chk("chain_op2", 32'(res_data[0]), 32'h0102);

        // Backpressure with a second command already waiting.
        start_op(0, 8'h3C, 8'h5A, 2'b01, 2'b01, 1'b0);
        cmd_x[0] = 8'h77; cmd_y[0] = 8'h88; cmd_s[0] = 2'b10; cmd_m[0] = 2'b00;
        cmd_chain[0] = 1'b0; cmd_valid[0] = 1'b1;
        finish_op(0, 5);
        start_op(0, 8'h77, 8'h88, 2'b10, 2'b00, 1'b0);
        chk("pending_accept_gap", 32'(t_acc[0] - t_hs[0]), 32'd10);
        finish_op(0, 0);
        chk("pending_data", 32'(res_data[0]), 32'h7788);

        // Four-cycle settle window and back-to-back period.
        start_op(1, 8'h0F, 8'hF0, 2'b01, 2'b11, 1'b0);
        begin
            longint t_first;
            t_first = t_acc[1];
            finish_op(1, 0);
            chk("settle4_data", 32'(res_data[1]), 32'h0FF0);
            start_op(1, 8'h21, 8'h43, 2'b00, 2'b01, 1'b0);
            chk("settle4_period", 32'(t_acc[1] - t_first), 32'd60);
            finish_op(1, 0);
        end

        // Randomized traffic on both instances.
        for (int n = 0; n < 40; n++) begin
            int u;
            u = int'($urandom_range(0, 1));
            start_op(u, 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                     1'($urandom_range(0, 1)));
            finish_op(u, int'($urandom_range(0, 3)));
        end

        // Reset mid-SETTLE, then mid-RESP with res_ready high.
        start_op(1, 8'hC3, 8'h3C, 2'b11, 2'b11, 1'b0);
        @(posedge clk);
        @(negedge clk);
        pulse_reset(1, 1'b0);
        start_op(1, 8'h5E, 8'hE5, 2'b10, 2'b01, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_res_valid", 32'(res_valid[1]), 1);
        pulse_reset(1, 1'b1);
        start_op(1, 8'hEE, 8'h66, 2'b00, 2'b00, 1'b1);
        finish_op(1, 0);
        chk("chain_after_midrst", 32'(res_data[1]), 32'h0066);

        // Counter wrap: preload near the top instead of 65k real handshakes.
        force dut1.op_count = 16'hFFFE;
        #1;
        release dut1.op_count;
        m_count[0] = 16'hFFFE;
        start_op(0, 8'h01, 8'h02, 2'b00, 2'b00, 1'b0);
        finish_op(0, 0);
        chk("count_ffff", 32'(op_count[0]), 32'hFFFF);
        start_op(0, 8'h03, 8'h04, 2'b00, 2'b00, 1'b0);
        finish_op(0, 0);
        chk("count_wrap", 32'(op_count[0]), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
